arbiter_puf_engine: RTL
=======================

ARBITER_PUF_ENGINE -- requirements
Module: arbiter_puf_engine

Interface
REQ-001 Parameter C_LENGTH, default 8; number of mux stages and challenge width; legal range 4..32.
REQ-002 Parameter N_SAMPLES, default 5; launches per response bit; must be odd, 1..15.
REQ-003 Parameter RESP_BITS, default 8; response bits per request; legal range 1..32.
REQ-004 Parameter SETTLE_CYC, default 2; idle cycles between launch and capture; legal range 1..15.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request pulse; accepted only while busy=0.
REQ-008 seed  in  C_LENGTH  first challenge; sampled on the accepting edge.
REQ-009 test_mode  in  1  1 = use test_bit instead of the arbiter core output.
REQ-010 test_bit  in  1  substitute raw bit; sampled in SAMPLE state.
REQ-011 busy  out  1  high from the accepting edge until DONE exits.
REQ-012 done  out  1  one-cycle pulse; response is valid.
REQ-013 response  out  RESP_BITS  majority-voted response; held until the next accepted start.
REQ-014 chal_out  out  C_LENGTH  challenge currently applied to the core.
REQ-015 unstable_cnt  out  $clog2(RESP_BITS+1)  count of bits with non-unanimous votes.

Function
REQ-016 FSM states: IDLE, LOAD, LAUNCH, SETTLE, SAMPLE, VOTE, DONE.
- IDLE: start=1 moves to LOAD.
- LOAD: challenge is loaded from seed, 1 cycle, then LAUNCH.
- LAUNCH: launch pulse to the core is high, 1 cycle.
- SETTLE: SETTLE_CYC cycles with the pulse low.
- SAMPLE: 1 cycle.
- VOTE: 1 cycle.
- DONE: 1 cycle, then IDLE.
REQ-017 SAMPLE: raw bit is captured; ones_cnt increments if raw=1; sample_cnt increments; if sample_cnt < N_SAMPLES-1 the FSM goes to LAUNCH, else to VOTE.
REQ-018 VOTE:
- bit = (ones_cnt > N_SAMPLES/2).
- response shifts left with bit entering the LSB, so the first bit ends at the MSB.
- The challenge advances one LFSR step; ones_cnt and sample_cnt clear.
- If the final bit is done, go to DONE; else go to LAUNCH.
REQ-019 LFSR: Galois, shift left, XOR with the package polynomial for C_LENGTH when the MSB=1.
REQ-020 A seed of all-zero is replaced by all-ones at LOAD to avoid LFSR lock-up.
REQ-021 done asserts exactly L = 1 + RESP_BITS*(N_SAMPLES*(SETTLE_CYC+2)+1) cycles after the accepting edge; with defaults L = 169.
REQ-022 start while busy=1 is ignored with no side effects.
REQ-023 start and DONE in the same cycle: start is ignored; a request is accepted only from IDLE.
REQ-024 response updates only in VOTE; it is cleared to 0 at the accepting edge.
REQ-025 test_mode is evaluated independently in every SAMPLE cycle.

Reset
REQ-026 rst=1 forces all of the following on the next edge, including mid-operation:
- FSM to IDLE.
- busy=0, done=0.
- response=0, chal_out=0, unstable_cnt=0.
- Launch pulse low; all counters cleared.
REQ-027 No done pulse is produced for an aborted request; the first start after rst is accepted normally.

Configuration
REQ-028 Macro PUF_STABILITY_EN, when defined: unstable_cnt increments in VOTE if 0 < ones_cnt < N_SAMPLES, and clears at the accepting edge.
REQ-029 Without PUF_STABILITY_EN: the unstable_cnt port is still present, driven constant 0, and no counter logic is built.

Structure
REQ-030 Package puf_pkg holds:
- The FSM state enum typedef.
- The LFSR polynomial constants per C_LENGTH (8: 0xB8; 16: 0xB400; 32: 0x80200003).
- The default parameter values.
REQ-031 Sub-module puf_arb_core holds the C_LENGTH cross-coupled mux-pair delay chain plus the capture flop clocked by the top path.
- The chain nets are marked dont_touch.
- The capture flop is reset-free.
REQ-032 The engine instantiates exactly one puf_arb_core and contains no other delay logic.

Verification
REQ-033 test_mode=1, test_bit=1, seed=0x5A, start -> busy=1, done at cycle 169, response=0xFF, unstable_cnt=0.
REQ-034 test_mode=1, test_bit=1 for 3 of 5 samples on bits 0,2,4,6 and for 2 of 5 on the others -> response=0xAA; unstable_cnt=8 when PUF_STABILITY_EN is defined, else 0.
REQ-035 seed=0x00 -> chal_out=0xFF during the first LAUNCH and 0x47 after the first VOTE.
REQ-036 Pulse start again at cycles 10 and 100 while busy -> exactly one done, at cycle 169, and response unchanged by the extra pulses.
REQ-037 rst at cycle 50 -> next cycle busy=0, response=0, no done. A new start then completes after 169 cycles.
REQ-038 test_mode=0, two requests with seed=0x3C -> both complete with done at 169 and identical responses.

Source files
------------

// File: rtl/puf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puf_pkg
// Description : Shared definitions for the arbiter PUF engine.
//               - engine FSM state encoding
//               - Galois LFSR feedback masks per challenge width
//               - default parameter values for the engine
// Revision    : 1.0  initial release
// ============================================================================
package puf_pkg;

    // Default engine configuration
    localparam int PUF_DEF_C_LENGTH   = 8;
    localparam int PUF_DEF_N_SAMPLES  = 5;
    localparam int PUF_DEF_RESP_BITS  = 8;
    localparam int PUF_DEF_SETTLE_CYC = 2;

    // Engine FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_VOTE   = 3'd5,
        ST_DONE   = 3'd6
    } puf_state_e;

    // Feedback masks for the widths the engine is normally built at
    localparam logic [31:0] PUF_POLY_8  = 32'h0000_00B8;
    localparam logic [31:0] PUF_POLY_16 = 32'h0000_B400;
    localparam logic [31:0] PUF_POLY_32 = 32'h8020_0003;

    // Feedback mask for any legal challenge width (4..32). Bit (t-1) is set
    // for every tap t of a maximal-length polynomial of that degree.
    function automatic logic [31:0] lfsr_poly(input int n);
        logic [31:0] p;
        p = 32'h0;
        case (n)
            4:       p = 32'h0000_000C;
            5:       p = 32'h0000_0014;
            6:       p = 32'h0000_0030;
            7:       p = 32'h0000_0060;
            8:       p = PUF_POLY_8;
            9:       p = 32'h0000_0110;
            10:      p = 32'h0000_0240;
            11:      p = 32'h0000_0500;
            12:      p = 32'h0000_0829;
            13:      p = 32'h0000_100D;
            14:      p = 32'h0000_2015;
            15:      p = 32'h0000_6000;
            16:      p = PUF_POLY_16;
            17:      p = 32'h0001_2000;
            18:      p = 32'h0002_0400;
            19:      p = 32'h0004_0023;
            20:      p = 32'h0009_0000;
            21:      p = 32'h0014_0000;
            22:      p = 32'h0030_0000;
            23:      p = 32'h0042_0000;
            24:      p = 32'h00E1_0000;
            25:      p = 32'h0120_0000;
            26:      p = 32'h0200_0023;
            27:      p = 32'h0400_0013;
            28:      p = 32'h0900_0000;
            29:      p = 32'h1400_0000;
            30:      p = 32'h2000_0029;
            31:      p = 32'h4800_0000;
            32:      p = PUF_POLY_32;
            default: p = PUF_POLY_8;
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/puf_arb_core.sv
`default_nettype none
// ============================================================================
// Module      : puf_arb_core
// Description : Arbiter PUF delay core. A launch edge races down two paths
//               through C_LENGTH cross-coupled mux pairs; each challenge bit
//               selects straight (1) or crossed (0) routing for its stage.
//               The capture flop is clocked by the top path and samples the
//               bottom path, so raw=1 means the bottom path won the race.
// Ports       : launch  - race start pulse from the engine
//               chal    - challenge, one bit per stage
//               raw     - arbiter decision of the most recent launch
// Revision    : 1.0  initial release
// ============================================================================
module puf_arb_core #(
    parameter int C_LENGTH = 8
) (
    input  logic                launch,
    input  logic [C_LENGTH-1:0] chal,
    output logic                raw
);

    // Each stage owns its nets so the chain is a set of distinct wires that
    // implementation tools can be told to leave untouched.
    for (genvar i = 0; i < C_LENGTH; i++) begin : g_stage
        logic top_in;
        logic bot_in;
        (* dont_touch = "true" *) logic top_w;
        (* dont_touch = "true" *) logic bot_w;

        if (i == 0) begin : g_head
            assign top_in = launch;
            assign bot_in = launch;
        end else begin : g_link
            assign top_in = g_stage[i-1].top_w;
            assign bot_in = g_stage[i-1].bot_w;
        end

        assign top_w = chal[i] ? top_in : bot_in;
        assign bot_w = chal[i] ? bot_in : top_in;
    end

    (* dont_touch = "true" *) logic top_end;
    (* dont_touch = "true" *) logic bot_end;
    assign top_end = g_stage[C_LENGTH-1].top_w;
    assign bot_end = g_stage[C_LENGTH-1].bot_w;

    // Arbiter flop: no reset, its clock is the race itself.
    logic raw_d;
    logic raw_q;

    always_comb begin
        raw_d = bot_end;
    end

    always_ff @(posedge top_end) begin
        raw_q <= raw_d;
    end

    assign raw = raw_q;

endmodule
`default_nettype wire

// File: rtl/arbiter_puf_engine.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_puf_engine
// Description : Drives one arbiter PUF core through LFSR-generated challenges,
//               launches each challenge N_SAMPLES times, majority-votes the
//               raw bits and shifts RESP_BITS voted bits into the response
//               (first bit ends up in the MSB).
// Ports       : clk, rst      - clock, synchronous active-high reset
//               start, seed   - request pulse and first challenge
//               test_mode     - 1 selects test_bit instead of the core output
//               test_bit      - substitute raw bit
//               busy, done    - request in flight / one-cycle completion
//               response      - voted response, held until next accept
//               chal_out      - challenge currently applied to the core
//               unstable_cnt  - bits whose votes were not unanimous
// Options     : `define PUF_STABILITY_EN builds the unstable-bit counter;
//               without it unstable_cnt is tied to zero.
// Revision    : 1.0  initial release
// ============================================================================
module arbiter_puf_engine
    import puf_pkg::*;
#(
    parameter int C_LENGTH   = PUF_DEF_C_LENGTH,    // 4..32
    parameter int N_SAMPLES  = PUF_DEF_N_SAMPLES,   // odd, 1..15
    parameter int RESP_BITS  = PUF_DEF_RESP_BITS,   // 1..32
    parameter int SETTLE_CYC = PUF_DEF_SETTLE_CYC   // 1..15
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [C_LENGTH-1:0]              seed,
    input  logic                             test_mode,
    input  logic                             test_bit,
    output logic                             busy,
    output logic                             done,
    output logic [RESP_BITS-1:0]             response,
    output logic [C_LENGTH-1:0]              chal_out,
    output logic [$clog2(RESP_BITS+1)-1:0]   unstable_cnt
);

    localparam int UC_W  = $clog2(RESP_BITS + 1);
    localparam int CNT_W = 4;

    localparam logic [C_LENGTH-1:0] C_POLY        = C_LENGTH'(lfsr_poly(C_LENGTH));
    localparam logic [CNT_W-1:0]    C_LAST_SAMPLE = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0]    C_HALF        = CNT_W'(N_SAMPLES / 2);
    localparam logic [CNT_W-1:0]    C_LAST_SETTLE = CNT_W'(SETTLE_CYC - 1);
    localparam logic [UC_W-1:0]     C_LAST_BIT    = UC_W'(RESP_BITS - 1);

    puf_state_e            state_q,  state_d;
    logic [C_LENGTH-1:0]   chal_q,   chal_d;
    logic [RESP_BITS-1:0]  resp_q,   resp_d;
    logic [CNT_W-1:0]      ones_q,   ones_d;
    logic [CNT_W-1:0]      smp_q,    smp_d;
    logic [CNT_W-1:0]      settle_q, settle_d;
    logic [UC_W-1:0]       bit_q,    bit_d;

    logic                  launch;
    logic                  core_raw;
    logic                  raw_bit;
    logic                  vote_bit;
    logic                  accept;
    logic [C_LENGTH-1:0]   lfsr_next;

    // ------------------------------------------------------------------
    // Delay core
    // ------------------------------------------------------------------
    puf_arb_core #(
        .C_LENGTH (C_LENGTH)
    ) u_core (
        .launch (launch),
        .chal   (chal_q),
        .raw    (core_raw)
    );

    assign launch   = (state_q == ST_LAUNCH);
    assign raw_bit  = test_mode ? test_bit : core_raw;
    assign vote_bit = (ones_q > C_HALF);
    assign accept   = (state_q == ST_IDLE) && start;

    // Galois step. The MSB is rotated into the LSB as the feedback term, so
    // the polynomial constant need not carry its x^0 tap explicitly.
    assign lfsr_next = {chal_q[C_LENGTH-2:0], chal_q[C_LENGTH-1]}
                     ^ (chal_q[C_LENGTH-1] ? C_POLY : {C_LENGTH{1'b0}});

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        chal_d   = chal_q;
        resp_d   = resp_q;
        ones_d   = ones_q;
        smp_d    = smp_q;
        settle_d = settle_q;
        bit_d    = bit_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    chal_d   = seed;
                    resp_d   = '0;
                    ones_d   = '0;
                    smp_d    = '0;
                    settle_d = '0;
                    bit_d    = '0;
                end
            end

            ST_LOAD: begin
                // An all-zero state would lock the LFSR.
                if (chal_q == '0) begin
                    chal_d = '1;
                end
                state_d = ST_LAUNCH;
            end

            ST_LAUNCH: begin
                settle_d = '0;
                state_d  = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (settle_q == C_LAST_SETTLE) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            ST_SAMPLE: begin
                ones_d = ones_q + CNT_W'(raw_bit);
                smp_d  = smp_q + 1'b1;
                if (smp_q < C_LAST_SAMPLE) begin
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_VOTE;
                end
            end

            ST_VOTE: begin
                resp_d = (resp_q << 1) | RESP_BITS'(vote_bit);
                chal_d = lfsr_next;
                ones_d = '0;
                smp_d  = '0;
                if (bit_q == C_LAST_BIT) begin
                    state_d = ST_DONE;
                end else begin
                    bit_d   = bit_q + 1'b1;
                    state_d = ST_LAUNCH;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            chal_q   <= '0;
            resp_q   <= '0;
            ones_q   <= '0;
            smp_q    <= '0;
            settle_q <= '0;
            bit_q    <= '0;
        end else begin
            state_q  <= state_d;
            chal_q   <= chal_d;
            resp_q   <= resp_d;
            ones_q   <= ones_d;
            smp_q    <= smp_d;
            settle_q <= settle_d;
            bit_q    <= bit_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional stability statistics
    // ------------------------------------------------------------------
`ifdef PUF_STABILITY_EN
    localparam logic [CNT_W-1:0] C_NS = CNT_W'(N_SAMPLES);

    logic [UC_W-1:0] unst_q, unst_d;

    always_comb begin
        unst_d = unst_q;
        if (accept) begin
            unst_d = '0;
        end else if ((state_q == ST_VOTE) && (ones_q != '0) && (ones_q != C_NS)) begin
            unst_d = unst_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            unst_q <= '0;
        end else begin
            unst_q <= unst_d;
        end
    end

    assign unstable_cnt = unst_q;
`else
    assign unstable_cnt = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign response = resp_q;
    assign chal_out = chal_q;

endmodule
`default_nettype wire
